// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller bus: stage destination info in, fetch control and counters out
interface pipe_hazard_ctrl_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   id_rs;
    logic [AW-1:0]   id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic [AW-1:0]   ex_rd;
    logic            ex_regwrite;
    logic            ex_memread;
    logic [AW-1:0]   mem_rd;
    logic            mem_regwrite;
    logic [AW-1:0]   wb_rd;
    logic            wb_regwrite;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] pc;
    logic [4:0]      valid;
    logic            stall;
    logic            flush;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [15:0]     stall_cnt;
    logic [15:0]     flush_cnt;
    logic [15:0]     retire_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_rd, ex_regwrite, ex_memread,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output br_taken, br_target,
        input  pc, valid, stall, flush, fwd_a, fwd_b,
        input  stall_cnt, flush_cnt, retire_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_rd, ex_regwrite, ex_memread,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  br_taken, br_target,
        output pc, valid, stall, flush, fwd_a, fwd_b,
        output stall_cnt, flush_cnt, retire_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard control: stall, branch flush, forwarding select, event counters
module pipe_hazard_ctrl #(
    parameter int              XLEN     = 32,
    parameter int              AW       = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              BR_STAGE = 3,
    parameter int              FWD_EN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [4:0]      valid_q, valid_d;
    logic [AW-1:0]   ex_rs_q, ex_rt_q;
    logic [15:0]     stall_cnt_q, flush_cnt_q, retire_cnt_q;
    logic            ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic            load_use, raw_hazard, stall_w, flush_w;
    logic [1:0]      fwd_a, fwd_b;

    // A producer only matters when its stage is live, it writes, and it is not r0.
    function automatic logic src_hit(input logic [AW-1:0] src, input logic used,
                                     input logic [AW-1:0] rd, input logic wr, input logic live);
        return used & live & wr & (rd != '0) & (rd == src);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
        return (en && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    endfunction

    assign ex_hit_rs  = src_hit(bus.id_rs, bus.id_use_rs, bus.ex_rd,  bus.ex_regwrite,  valid_q[2]);
    assign ex_hit_rt  = src_hit(bus.id_rt, bus.id_use_rt, bus.ex_rd,  bus.ex_regwrite,  valid_q[2]);
    assign mem_hit_rs = src_hit(bus.id_rs, bus.id_use_rs, bus.mem_rd, bus.mem_regwrite, valid_q[3]);
    assign mem_hit_rt = src_hit(bus.id_rt, bus.id_use_rt, bus.mem_rd, bus.mem_regwrite, valid_q[3]);

    assign load_use   = valid_q[1] & bus.ex_memread & (ex_hit_rs | ex_hit_rt);
    assign raw_hazard = valid_q[1] & (ex_hit_rs | ex_hit_rt | mem_hit_rs | mem_hit_rt);

    // A taken branch kills the stalled instruction anyway, so flush masks stall.
    assign flush_w = ~reset & bus.br_taken & valid_q[BR_STAGE];
    assign stall_w = ~reset & ~flush_w & ((FWD_EN != 0) ? load_use : raw_hazard);

    // EX operands are matched against the sources latched from ID one cycle earlier.
    assign fwd_a = (FWD_EN == 0) ? 2'b00 :
                   src_hit(ex_rs_q, 1'b1, bus.mem_rd, bus.mem_regwrite, valid_q[3]) ? 2'b01 :
                   src_hit(ex_rs_q, 1'b1, bus.wb_rd,  bus.wb_regwrite,  valid_q[4]) ? 2'b10 : 2'b00;
    assign fwd_b = (FWD_EN == 0) ? 2'b00 :
                   src_hit(ex_rt_q, 1'b1, bus.mem_rd, bus.mem_regwrite, valid_q[3]) ? 2'b01 :
                   src_hit(ex_rt_q, 1'b1, bus.wb_rd,  bus.wb_regwrite,  valid_q[4]) ? 2'b10 : 2'b00;

    always_comb begin
        pc_d    = pc_q + PC_STEP;
        valid_d = {valid_q[3:0], 1'b1};
        if (flush_w) begin
            pc_d                = bus.br_target;
            valid_d[BR_STAGE:1] = '0;
        end else if (stall_w) begin
            pc_d         = pc_q;
            valid_d[1:0] = valid_q[1:0];
            valid_d[2]   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            valid_q      <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            ex_rs_q      <= bus.id_rs;
            ex_rt_q      <= bus.id_rt;
            stall_cnt_q  <= sat_inc(stall_cnt_q, stall_w);
            flush_cnt_q  <= sat_inc(flush_cnt_q, flush_w);
            retire_cnt_q <= sat_inc(retire_cnt_q, valid_q[4]);
        end
    end

    assign bus.pc         = pc_q;
    assign bus.valid      = valid_q;
    assign bus.stall      = stall_w;
    assign bus.flush      = flush_w;
    assign bus.fwd_a      = fwd_a;
    assign bus.fwd_b      = fwd_b;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
    assign bus.retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - bench for pipe_hazard_ctrl: directed scenarios plus random run against a stage model
module tb_pipe_hazard_ctrl;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [AW-1:0]   id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic            id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, br_taken;
    logic [XLEN-1:0] br_target;

    pipe_hazard_ctrl_if #(.XLEN(XLEN), .AW(AW)) bus0 ();
    pipe_hazard_ctrl_if #(.XLEN(XLEN), .AW(AW)) bus1 ();

    assign bus0.id_rs = id_rs;             assign bus1.id_rs = id_rs;
    assign bus0.id_rt = id_rt;             assign bus1.id_rt = id_rt;
    assign bus0.id_use_rs = id_use_rs;     assign bus1.id_use_rs = id_use_rs;
    assign bus0.id_use_rt = id_use_rt;     assign bus1.id_use_rt = id_use_rt;
    assign bus0.ex_rd = ex_rd;             assign bus1.ex_rd = ex_rd;
    assign bus0.ex_regwrite = ex_regwrite; assign bus1.ex_regwrite = ex_regwrite;
    assign bus0.ex_memread = ex_memread;   assign bus1.ex_memread = ex_memread;
    assign bus0.mem_rd = mem_rd;           assign bus1.mem_rd = mem_rd;
    assign bus0.mem_regwrite = mem_regwrite; assign bus1.mem_regwrite = mem_regwrite;
    assign bus0.wb_rd = wb_rd;             assign bus1.wb_rd = wb_rd;
    assign bus0.wb_regwrite = wb_regwrite; assign bus1.wb_regwrite = wb_regwrite;
    assign bus0.br_taken = br_taken;       assign bus1.br_taken = br_taken;
    assign bus0.br_target = br_target;     assign bus1.br_target = br_target;

    logic [XLEN-1:0] o_pc[2];
    logic [4:0]      o_valid[2];
    logic            o_stall[2], o_flush[2];
    logic [1:0]      o_fa[2], o_fb[2];
    logic [15:0]     o_sc[2], o_fc[2], o_rc[2];

    assign o_pc[0] = bus0.pc;       assign o_pc[1] = bus1.pc;
    assign o_valid[0] = bus0.valid; assign o_valid[1] = bus1.valid;
    assign o_stall[0] = bus0.stall; assign o_stall[1] = bus1.stall;
    assign o_flush[0] = bus0.flush; assign o_flush[1] = bus1.flush;
    assign o_fa[0] = bus0.fwd_a;    assign o_fa[1] = bus1.fwd_a;
    assign o_fb[0] = bus0.fwd_b;    assign o_fb[1] = bus1.fwd_b;
    assign o_sc[0] = bus0.stall_cnt;  assign o_sc[1] = bus1.stall_cnt;
    assign o_fc[0] = bus0.flush_cnt;  assign o_fc[1] = bus1.flush_cnt;
    assign o_rc[0] = bus0.retire_cnt; assign o_rc[1] = bus1.retire_cnt;

    pipe_hazard_ctrl #(.XLEN(XLEN), .AW(AW), .RESET_PC(32'h40), .BR_STAGE(3), .FWD_EN(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    pipe_hazard_ctrl #(.XLEN(XLEN), .AW(AW), .RESET_PC(32'h0), .BR_STAGE(2), .FWD_EN(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    // Reference: per-DUT stage occupancy, fetch address, counters, latched EX sources.
    int          m_br[2];
    bit          m_fe[2];
    logic [31:0] m_rp[2];
    logic [31:0] m_pc[2];
    bit          m_v[2][5];
    int          m_sc[2], m_fc[2], m_rc[2];
    logic [AW-1:0] m_xrs[2], m_xrt[2];
    bit          e_stall[2], e_flush[2];
    logic [1:0]  e_fa[2], e_fb[2];
    int          n_chk, n_fail;

    function automatic bit hits(logic [AW-1:0] src, bit used, logic [AW-1:0] rd, bit wr, bit live);
        return used && live && wr && rd != 0 && rd == src;
    endfunction

    function automatic logic [1:0] fwd_ref(int k, logic [AW-1:0] src);
        if (!m_fe[k]) return 2'd0;
        if (hits(src, 1, mem_rd, mem_regwrite, m_v[k][3])) return 2'd1;
        if (hits(src, 1, wb_rd, wb_regwrite, m_v[k][4])) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [4:0] mv(int k);
        logic [4:0] r;
        for (int s = 0; s < 5; s++) r[s] = m_v[k][s];
        return r;
    endfunction

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            bit ex_any, mem_any, lu;
            ex_any  = hits(id_rs, id_use_rs, ex_rd, ex_regwrite, m_v[k][2]) ||
                      hits(id_rt, id_use_rt, ex_rd, ex_regwrite, m_v[k][2]);
            mem_any = hits(id_rs, id_use_rs, mem_rd, mem_regwrite, m_v[k][3]) ||
                      hits(id_rt, id_use_rt, mem_rd, mem_regwrite, m_v[k][3]);
            lu = m_v[k][1] && ex_memread && ex_any;
            e_flush[k] = !reset && br_taken && m_v[k][m_br[k]];
            e_stall[k] = !reset && !e_flush[k] && (m_fe[k] ? lu : (m_v[k][1] && (ex_any || mem_any)));
            e_fa[k] = fwd_ref(k, m_xrs[k]);
            e_fb[k] = fwd_ref(k, m_xrt[k]);
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit nv[5];
            if (reset) begin
                m_pc[k] = m_rp[k];
                for (int s = 0; s < 5; s++) m_v[k][s] = 0;
                m_sc[k] = 0; m_fc[k] = 0; m_rc[k] = 0;
                m_xrs[k] = 0; m_xrt[k] = 0;
            end else begin
                if (m_v[k][4] && m_rc[k] < 65535) m_rc[k]++;
                nv[0] = 1;
                for (int s = 1; s < 5; s++) nv[s] = m_v[k][s-1];
                if (e_flush[k]) begin
                    for (int s = 1; s <= m_br[k]; s++) nv[s] = 0;
                    m_pc[k] = br_target;
                    if (m_fc[k] < 65535) m_fc[k]++;
                end else if (e_stall[k]) begin
                    nv[0] = m_v[k][0]; nv[1] = m_v[k][1]; nv[2] = 0;
                    if (m_sc[k] < 65535) m_sc[k]++;
                end else begin
                    m_pc[k] = m_pc[k] + 32'd4;
                end
                m_v[k] = nv;
                m_xrs[k] = id_rs; m_xrt[k] = id_rt;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        reset = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0; mem_rd = 0; mem_regwrite = 0;
        wb_rd = 0; wb_regwrite = 0; br_taken = 0; br_target = 0;
    endtask

    task automatic idle_cycles(int n);
        set_idle();
        repeat (n) tick();
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    endtask

    task automatic test_reset();
        set_idle(); reset = 1; set_load_use(); br_taken = 1; br_target = 32'h500;
        tick(); tick(); #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_pc[k] !== m_rp[k]) begin n_fail++; $display("FAIL reset_pc dut%0d got %h exp %h", k, o_pc[k], m_rp[k]); end
            n_chk++; if (o_valid[k] !== 5'b0) begin n_fail++; $display("FAIL reset_valid dut%0d got %b exp 00000", k, o_valid[k]); end
            n_chk++; if ({o_stall[k], o_flush[k]} !== 2'b00) begin n_fail++; $display("FAIL reset_stall_flush dut%0d got %b exp 00", k, {o_stall[k], o_flush[k]}); end
            n_chk++; if ({o_sc[k], o_fc[k], o_rc[k]} !== 48'h0) begin n_fail++; $display("FAIL reset_cnt dut%0d got %h exp 0", k, {o_sc[k], o_fc[k], o_rc[k]}); end
        end
    endtask

    task automatic test_release();
        set_idle(); br_taken = 1; br_target = 32'h900;
        tick(); #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_valid[k] !== 5'b00001) begin n_fail++; $display("FAIL release_valid dut%0d got %b exp 00001", k, o_valid[k]); end
            n_chk++; if (o_pc[k] !== m_rp[k] + 32'd4) begin n_fail++; $display("FAIL release_pc dut%0d got %h exp %h", k, o_pc[k], m_rp[k] + 32'd4); end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] pc_before;
        idle_cycles(4);
        set_load_use(); #1;
        pc_before = o_pc[0];
        n_chk++; if (o_stall[0] !== 1'b1) begin n_fail++; $display("FAIL lu_stall dut0 got %b exp 1", o_stall[0]); end
        n_chk++; if (o_stall[1] !== 1'b1) begin n_fail++; $display("FAIL lu_stall_nofwd dut1 got %b exp 1", o_stall[1]); end
        tick(); set_idle(); #1;
        n_chk++; if (o_pc[0] !== pc_before) begin n_fail++; $display("FAIL lu_pc_hold got %h exp %h", o_pc[0], pc_before); end
        n_chk++; if (o_valid[0] !== 5'b11011) begin n_fail++; $display("FAIL lu_bubble got %b exp 11011", o_valid[0]); end
        n_chk++; if (o_sc[0] !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d exp 1", o_sc[0]); end
    endtask

    task automatic test_forward_priority();
        set_idle(); id_rs = 3; id_rt = 7;
        repeat (3) tick();
        mem_rd = 3; mem_regwrite = 1; wb_rd = 3; wb_regwrite = 1; #1;
        n_chk++; if (o_fa[0] !== 2'b01) begin n_fail++; $display("FAIL fwd_mem_prio got %b exp 01", o_fa[0]); end
        n_chk++; if (o_fb[0] !== 2'b00) begin n_fail++; $display("FAIL fwd_b_nomatch got %b exp 00", o_fb[0]); end
        n_chk++; if (o_fa[1] !== 2'b00) begin n_fail++; $display("FAIL fwd_disabled dut1 got %b exp 00", o_fa[1]); end
        mem_regwrite = 0; #1;
        n_chk++; if (o_fa[0] !== 2'b10) begin n_fail++; $display("FAIL fwd_wb got %b exp 10", o_fa[0]); end
        idle_cycles(1);
    endtask

    task automatic test_reg_zero();
        set_idle();
        ex_memread = 1; ex_regwrite = 1; id_use_rs = 1; mem_regwrite = 1; wb_regwrite = 1; #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_stall[k] !== 1'b0) begin n_fail++; $display("FAIL r0_stall dut%0d got %b exp 0", k, o_stall[k]); end
            n_chk++; if (o_fa[k] !== 2'b00) begin n_fail++; $display("FAIL r0_fwd dut%0d got %b exp 00", k, o_fa[k]); end
        end
        idle_cycles(1);
    endtask

    task automatic test_branch();
        idle_cycles(4);
        br_taken = 1; br_target = 32'h100; #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_flush[k] !== 1'b1) begin n_fail++; $display("FAIL br_flush dut%0d got %b exp 1", k, o_flush[k]); end
        end
        tick(); set_idle(); #1;
        n_chk++; if (o_valid[0] !== 5'b10001) begin n_fail++; $display("FAIL br_valid_s3 got %b exp 10001", o_valid[0]); end
        n_chk++; if (o_valid[1] !== 5'b11001) begin n_fail++; $display("FAIL br_valid_s2 got %b exp 11001", o_valid[1]); end
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_pc[k] !== 32'h100) begin n_fail++; $display("FAIL br_pc dut%0d got %h exp 100", k, o_pc[k]); end
            n_chk++; if (o_fc[k] !== 16'd1) begin n_fail++; $display("FAIL br_flush_cnt dut%0d got %0d exp 1", k, o_fc[k]); end
        end
    endtask

    task automatic test_flush_and_stall();
        logic [15:0] sc_before;
        idle_cycles(4);
        sc_before = o_sc[0];
        set_load_use(); br_taken = 1; br_target = 32'h200; #1;
        n_chk++; if ({o_flush[0], o_stall[0]} !== 2'b10) begin n_fail++; $display("FAIL fs_outputs got %b exp 10", {o_flush[0], o_stall[0]}); end
        tick(); set_idle(); #1;
        n_chk++; if (o_sc[0] !== sc_before) begin n_fail++; $display("FAIL fs_stall_cnt got %0d exp %0d", o_sc[0], sc_before); end
        n_chk++; if (o_fc[0] !== 16'd2) begin n_fail++; $display("FAIL fs_flush_cnt got %0d exp 2", o_fc[0]); end
        n_chk++; if (o_pc[0] !== 32'h200) begin n_fail++; $display("FAIL fs_pc got %h exp 200", o_pc[0]); end
    endtask

    task automatic test_ignored_branch();
        logic [31:0] pc_before[2];
        set_idle(); br_taken = 1; br_target = 32'h300; #1;
        for (int k = 0; k < 2; k++) begin
            pc_before[k] = o_pc[k];
            n_chk++; if (o_flush[k] !== 1'b0) begin n_fail++; $display("FAIL ign_flush dut%0d got %b exp 0", k, o_flush[k]); end
        end
        tick(); #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_pc[k] !== pc_before[k] + 32'd4) begin n_fail++; $display("FAIL ign_pc dut%0d got %h exp %h", k, o_pc[k], pc_before[k] + 32'd4); end
        end
    endtask

    task automatic test_pc_wrap();
        idle_cycles(4);
        br_taken = 1; br_target = 32'hFFFF_FFFC;
        tick(); set_idle(); #1;
        n_chk++; if (o_pc[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_load got %h exp fffffffc", o_pc[0]); end
        tick(); #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (o_pc[k] !== 32'h0) begin n_fail++; $display("FAIL wrap_zero dut%0d got %h exp 0", k, o_pc[k]); end
        end
    endtask

    task automatic test_reset_mid_stall();
        idle_cycles(4);
        set_load_use(); br_taken = 1; br_target = 32'h700; br_taken = 0; #1;
        n_chk++; if (o_stall[0] !== 1'b1) begin n_fail++; $display("FAIL rms_pre_stall got %b exp 1", o_stall[0]); end
        reset = 1; br_taken = 1; #1;
        n_chk++; if ({o_stall[0], o_flush[0]} !== 2'b00) begin n_fail++; $display("FAIL rms_outputs got %b exp 00", {o_stall[0], o_flush[0]}); end
        tick(); #1;
        n_chk++; if (o_pc[0] !== 32'h40) begin n_fail++; $display("FAIL rms_pc got %h exp 40", o_pc[0]); end
        n_chk++; if (o_valid[0] !== 5'b0) begin n_fail++; $display("FAIL rms_valid got %b exp 00000", o_valid[0]); end
        n_chk++; if ({o_sc[0], o_fc[0], o_rc[0]} !== 48'h0) begin n_fail++; $display("FAIL rms_cnt got %h exp 0", {o_sc[0], o_fc[0], o_rc[0]}); end
        set_idle(); tick(); #1;
        n_chk++; if ({o_valid[0], o_pc[0]} !== {5'b00001, 32'h44}) begin n_fail++; $display("FAIL rms_release got %b/%h exp 00001/44", o_valid[0], o_pc[0]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            id_rs = AW'($urandom_range(0, 3)); id_rt = AW'($urandom_range(0, 3));
            id_use_rs = 1'($urandom_range(0, 1)); id_use_rt = 1'($urandom_range(0, 1));
            ex_rd = AW'($urandom_range(0, 3)); mem_rd = AW'($urandom_range(0, 3)); wb_rd = AW'($urandom_range(0, 3));
            ex_memread = ($urandom_range(0, 3) == 0);
            ex_regwrite = ex_memread | 1'($urandom_range(0, 1));
            mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
            br_taken = ($urandom_range(0, 7) == 0); br_target = $urandom;
            #1; model_eval();
            for (int k = 0; k < 2; k++) begin
                n_chk++; if (o_stall[k] !== e_stall[k]) begin n_fail++; $display("FAIL rnd_stall dut%0d c%0d got %b exp %b", k, c, o_stall[k], e_stall[k]); end
                n_chk++; if (o_flush[k] !== e_flush[k]) begin n_fail++; $display("FAIL rnd_flush dut%0d c%0d got %b exp %b", k, c, o_flush[k], e_flush[k]); end
                n_chk++; if ({o_fa[k], o_fb[k]} !== {e_fa[k], e_fb[k]}) begin n_fail++; $display("FAIL rnd_fwd dut%0d c%0d got %b exp %b", k, c, {o_fa[k], o_fb[k]}, {e_fa[k], e_fb[k]}); end
                n_chk++; if (o_pc[k] !== m_pc[k]) begin n_fail++; $display("FAIL rnd_pc dut%0d c%0d got %h exp %h", k, c, o_pc[k], m_pc[k]); end
                n_chk++; if (o_valid[k] !== mv(k)) begin n_fail++; $display("FAIL rnd_valid dut%0d c%0d got %b exp %b", k, c, o_valid[k], mv(k)); end
                n_chk++; if ({o_sc[k], o_fc[k], o_rc[k]} !== {16'(m_sc[k]), 16'(m_fc[k]), 16'(m_rc[k])}) begin
                    n_fail++; $display("FAIL rnd_cnt dut%0d c%0d got %0d/%0d/%0d exp %0d/%0d/%0d", k, c, o_sc[k], o_fc[k], o_rc[k], m_sc[k], m_fc[k], m_rc[k]);
                end
            end
            tick();
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        m_br[0] = 3; m_br[1] = 2;
        m_fe[0] = 1; m_fe[1] = 0;
        m_rp[0] = 32'h40; m_rp[1] = 32'h0;
        test_reset();
        test_release();
        test_load_use();
        test_forward_priority();
        test_reg_zero();
        test_branch();
        test_flush_and_stall();
        test_ignored_branch();
        test_pc_wrap();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
